// File: rtl/vx_tag_flush_ctrl_pkg.sv
// Shared types and geometry helpers for the tag-store flush sequencer.
// Module parameters differ per instance, so geometry is derived through functions here.
package vx_tag_flush_ctrl_pkg;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_FLUSH = 2'd2
  } flush_state_e;

  // LINES_PER_BANK: never below one line, so a degenerate geometry still walks once.
  function automatic int calc_lines_per_bank(input int cache_size, input int line_size,
                                             input int num_banks);
    int lines;
    lines = cache_size / (line_size * num_banks);
    return (lines < 1) ? 1 : lines;
  endfunction

  // LINE_SELECT_BITS, also the walk-counter width.
  function automatic int calc_line_select_bits(input int lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

  // Line address width: word address width minus the word-in-line select bits.
  function automatic int calc_line_addr_width(input int line_size, input int word_size);
    int words_per_line;
    words_per_line = (line_size > word_size) ? (line_size / word_size) : 1;
    return (32 - $clog2(word_size)) - $clog2(words_per_line);
  endfunction

endpackage

// File: rtl/vx_line_walker.sv
// Line-index walker: counts 0..NUM_LINES-1 on enable, wraps after the last line.
// Shared by the tag-store flush sequencer and the data-store init path.
module vx_line_walker #(
  parameter int NUM_LINES = 4,
  parameter int SEL_W     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [SEL_W-1:0] cnt_o,
  output logic             last_o
);

  logic [SEL_W-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == SEL_W'(NUM_LINES - 1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_o ? '0 : cnt_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vx_tag_flush_ctrl.sv
// Arbitrates the tag store's single port between flush walk, fill and lookup.
// Grants are combinational in the request cycle; busy/flush_done are registered.
module vx_tag_flush_ctrl
  import vx_tag_flush_ctrl_pkg::*;
#(
  parameter int CACHE_ID         = 0,
  parameter int BANK_ID          = 0,
  parameter int CACHE_SIZE       = 1,
  parameter int CACHE_LINE_SIZE  = 1,
  parameter int NUM_BANKS        = 1,
  parameter int WORD_SIZE        = 1,
  parameter int BANK_ADDR_OFFSET = 0,
  parameter int INIT_ON_RESET    = 1,
  localparam int LAW             = calc_line_addr_width(CACHE_LINE_SIZE, WORD_SIZE)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall,
  input  logic           flush_req_valid,
  output logic           flush_req_ready,
  input  logic           fill_valid,
  input  logic [LAW-1:0] fill_addr,
  input  logic           fill_should_reserve,
  input  logic           fill_is_write,
  output logic           fill_ready,
  input  logic           lookup_valid,
  input  logic [LAW-1:0] lookup_addr,
  output logic           lookup_ready,
  output logic           tag_lookup,
  output logic           tag_fill,
  output logic           tag_flush,
  output logic [LAW-1:0] tag_addr,
  output logic           tag_is_write,
  output logic           tag_should_reserve,
  output logic           busy,
  output logic           flush_done
);

  localparam int LINES_PER_BANK   = calc_lines_per_bank(CACHE_SIZE, CACHE_LINE_SIZE, NUM_BANKS);
  localparam int LINE_SELECT_BITS = calc_line_select_bits(LINES_PER_BANK);

  flush_state_e                state_q;
  logic                        busy_q;
  logic                        flush_done_q;
  logic [LINE_SELECT_BITS-1:0] walk_cnt;
  logic                        walk_last;
  logic                        walk_en;
  logic                        walking;

  assign walking = (state_q != S_IDLE);

  vx_line_walker #(
    .NUM_LINES (LINES_PER_BANK),
    .SEL_W     (LINE_SELECT_BITS)
  ) u_walker (
    .clk    (clk),
    .rst_n  (reset),
    .en_i   (walk_en),
    .clr_i  (flush_req_ready),
    .cnt_o  (walk_cnt),
    .last_o (walk_last)
  );

  // Fixed priority: walk > flush request > fill > lookup; reset forces everything quiet.
  always_comb begin
    flush_req_ready    = 1'b0;
    fill_ready         = 1'b0;
    lookup_ready       = 1'b0;
    tag_lookup         = 1'b0;
    tag_fill           = 1'b0;
    tag_flush          = 1'b0;
    tag_addr           = '0;
    tag_is_write       = 1'b0;
    tag_should_reserve = 1'b0;
    walk_en            = 1'b0;
    if (reset && !stall) begin
      if (walking) begin
        tag_flush = 1'b1;
        tag_addr  = LAW'(walk_cnt);
        walk_en   = 1'b1;
      end else if (flush_req_valid) begin
        flush_req_ready = 1'b1;
      end else if (fill_valid) begin
        fill_ready         = 1'b1;
        tag_fill           = 1'b1;
        tag_addr           = fill_addr;
        tag_is_write       = fill_is_write;
        tag_should_reserve = fill_should_reserve;
      end else if (lookup_valid) begin
        lookup_ready = 1'b1;
        tag_lookup   = 1'b1;
        tag_addr     = lookup_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= (INIT_ON_RESET != 0) ? S_INIT : S_IDLE;
      busy_q       <= (INIT_ON_RESET != 0);
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      case (state_q)
        S_INIT, S_FLUSH: begin
          if (walk_en && walk_last) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            flush_done_q <= 1'b1;
          end
        end
        S_IDLE: begin
          if (flush_req_ready) begin
            state_q <= S_FLUSH;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign flush_done = flush_done_q;

endmodule

// File: tb/tb_vx_tag_flush_ctrl.sv
// Bench for vx_tag_flush_ctrl: per-cycle vector table through a scoreboard queue,
// then a hand-driven flush walk with intermittent stalls checked against expected addresses.
module tb_vx_tag_flush_ctrl;

  localparam int LAW = 28;

  typedef struct packed {
    logic           rst;
    logic           stl;
    logic           frv;
    logic           fv;
    logic [LAW-1:0] fa;
    logic           fiw;
    logic           fsr;
    logic           lv;
    logic [LAW-1:0] la;
  } in_t;

  typedef struct packed {
    logic           frr;
    logic           fr;
    logic           lr;
    logic           tl;
    logic           tf;
    logic           tfl;
    logic [LAW-1:0] addr;
    logic           iw;
    logic           sr;
    logic           bz;
    logic           dn;
  } out_t;

  typedef struct {
    string nm;
    in_t   i;
    out_t  o;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           stall;
  logic           flush_req_valid;
  logic           flush_req_ready;
  logic           fill_valid;
  logic [LAW-1:0] fill_addr;
  logic           fill_should_reserve;
  logic           fill_is_write;
  logic           fill_ready;
  logic           lookup_valid;
  logic [LAW-1:0] lookup_addr;
  logic           lookup_ready;
  logic           tag_lookup;
  logic           tag_fill;
  logic           tag_flush;
  logic [LAW-1:0] tag_addr;
  logic           tag_is_write;
  logic           tag_should_reserve;
  logic           busy;
  logic           flush_done;

  int n_vec = 0;
  int n_bad = 0;

  vec_t           tbl[$];
  vec_t           exp_q[$];
  logic [LAW-1:0] addr_q[$];
  out_t           act;

  always #5 clk = ~clk;

  vx_tag_flush_ctrl #(
    .CACHE_ID         (0),
    .BANK_ID          (0),
    .CACHE_SIZE       (256),
    .CACHE_LINE_SIZE  (16),
    .NUM_BANKS        (4),
    .WORD_SIZE        (4),
    .BANK_ADDR_OFFSET (0),
    .INIT_ON_RESET    (1)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .stall               (stall),
    .flush_req_valid     (flush_req_valid),
    .flush_req_ready     (flush_req_ready),
    .fill_valid          (fill_valid),
    .fill_addr           (fill_addr),
    .fill_should_reserve (fill_should_reserve),
    .fill_is_write       (fill_is_write),
    .fill_ready          (fill_ready),
    .lookup_valid        (lookup_valid),
    .lookup_addr         (lookup_addr),
    .lookup_ready        (lookup_ready),
    .tag_lookup          (tag_lookup),
    .tag_fill            (tag_fill),
    .tag_flush           (tag_flush),
    .tag_addr            (tag_addr),
    .tag_is_write        (tag_is_write),
    .tag_should_reserve  (tag_should_reserve),
    .busy                (busy),
    .flush_done          (flush_done)
  );

  assign act = {flush_req_ready, fill_ready, lookup_ready, tag_lookup, tag_fill, tag_flush,
                tag_addr, tag_is_write, tag_should_reserve, busy, flush_done};

  function automatic in_t mi(bit rst, bit stl, bit frv, bit fv, logic [LAW-1:0] fa,
                             bit fiw, bit fsr, bit lv, logic [LAW-1:0] la);
    return '{rst: rst, stl: stl, frv: frv, fv: fv, fa: fa, fiw: fiw, fsr: fsr, lv: lv, la: la};
  endfunction

  function automatic out_t mo(bit frr, bit fr, bit lr, bit tl, bit tf, bit tfl,
                              logic [LAW-1:0] a, bit iw, bit sr, bit bz, bit dn);
    return '{frr: frr, fr: fr, lr: lr, tl: tl, tf: tf, tfl: tfl, addr: a,
             iw: iw, sr: sr, bz: bz, dn: dn};
  endfunction

  task automatic add(string nm, in_t i, out_t o);
    vec_t v;
    v.nm = nm;
    v.i  = i;
    v.o  = o;
    tbl.push_back(v);
  endtask

  task automatic drive(in_t i);
    reset               = i.rst;
    stall               = i.stl;
    flush_req_valid     = i.frv;
    fill_valid          = i.fv;
    fill_addr           = i.fa;
    fill_is_write       = i.fiw;
    fill_should_reserve = i.fsr;
    lookup_valid        = i.lv;
    lookup_addr         = i.la;
  endtask

  task automatic check(string nm, logic [63:0] a, logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, a, e);
    end
  endtask

  // Walk with a stall on every third cycle; each tag_flush must match the next expected line.
  task automatic stalled_walk();
    bit seen_done;
    seen_done = 1'b0;
    drive(mi(1, 0, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("hs_accept", 64'(flush_req_ready), 64'd1);
    for (int a = 0; a < 4; a++) addr_q.push_back(LAW'(a));
    for (int c = 0; c < 40 && !seen_done; c++) begin
      @(posedge clk); #1;
      drive(mi(1, (c % 3) == 1, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      if (stall) check("hs_stall_quiet", 64'(tag_flush), 64'd0);
      if (tag_flush) begin
        if (addr_q.size() == 0) check("hs_extra_flush", 64'(tag_addr), 64'hFFFF);
        else check("hs_flush_addr", 64'(tag_addr), 64'(addr_q.pop_front()));
      end
      if (flush_done) seen_done = 1'b1;
    end
    check("hs_done_seen", 64'(seen_done), 64'd1);
    check("hs_lines_left", 64'(addr_q.size()), 64'd0);
  endtask

  initial begin
    drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset state and the automatic init walk.
    add("rst_state",   mi(0, 0, 0, 0, 0, 0, 0, 0, 0),         mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    add("init_a0",     mi(1, 0, 0, 0, 0, 0, 0, 0, 0),         mo(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    add("init_a1",     mi(1, 0, 0, 0, 0, 0, 0, 0, 0),         mo(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0));
    add("init_a2",     mi(1, 0, 0, 0, 0, 0, 0, 0, 0),         mo(0, 0, 0, 0, 0, 1, 2, 0, 0, 1, 0));
    add("init_a3",     mi(1, 0, 0, 0, 0, 0, 0, 0, 0),         mo(0, 0, 0, 0, 0, 1, 3, 0, 0, 1, 0));
    add("init_done",   mi(1, 0, 0, 0, 0, 0, 0, 0, 0),         mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add("idle_quiet",  mi(1, 0, 0, 0, 0, 0, 0, 0, 0),         mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Fill beats lookup; lookup granted once fill drops.
    add("fill_wins",   mi(1, 0, 0, 1, 'h123, 0, 0, 1, 'h456), mo(0, 1, 0, 0, 1, 0, 'h123, 0, 0, 0, 0));
    add("lookup_next", mi(1, 0, 0, 0, 0, 0, 0, 1, 'h456),     mo(0, 0, 1, 1, 0, 0, 'h456, 0, 0, 0, 0));
    // is_write/should_reserve only pass through on a fill.
    add("fill_wr_rsv", mi(1, 0, 0, 1, 'hABC, 1, 1, 0, 0),     mo(0, 1, 0, 0, 1, 0, 'hABC, 1, 1, 0, 0));
    add("lkp_no_wr",   mi(1, 0, 0, 0, 0, 1, 1, 1, 'h77),      mo(0, 0, 1, 1, 0, 0, 'h77, 0, 0, 0, 0));
    add("idle_stall",  mi(1, 1, 1, 1, 'h9, 0, 0, 1, 'h8),     mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Flush request beats fill; walk with a stall at line 2; fill waits for the walk.
    add("flush_wins",  mi(1, 0, 1, 1, 'h55, 0, 0, 0, 0),      mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("fl_a0",       mi(1, 0, 0, 1, 'h55, 0, 0, 0, 0),      mo(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    add("fl_a1",       mi(1, 0, 0, 1, 'h55, 0, 0, 0, 0),      mo(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0));
    add("fl_stall",    mi(1, 1, 0, 1, 'h55, 0, 0, 0, 0),      mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    add("fl_a2",       mi(1, 0, 0, 1, 'h55, 0, 0, 0, 0),      mo(0, 0, 0, 0, 0, 1, 2, 0, 0, 1, 0));
    add("fl_a3",       mi(1, 0, 0, 1, 'h55, 0, 0, 0, 0),      mo(0, 0, 0, 0, 0, 1, 3, 0, 0, 1, 0));
    add("fill_after",  mi(1, 0, 0, 1, 'h55, 0, 0, 0, 0),      mo(0, 1, 0, 0, 1, 0, 'h55, 0, 0, 0, 1));
    add("idle_2",      mi(1, 0, 0, 0, 0, 0, 0, 0, 0),         mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Flush request held during a walk is accepted again afterwards, not merged.
    add("fr_accept",   mi(1, 0, 1, 0, 0, 0, 0, 0, 0),         mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("fr_hold_a0",  mi(1, 0, 1, 0, 0, 0, 0, 0, 0),         mo(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    add("fr_hold_a1",  mi(1, 0, 1, 0, 0, 0, 0, 0, 0),         mo(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0));
    add("fr_hold_a2",  mi(1, 0, 1, 0, 0, 0, 0, 0, 0),         mo(0, 0, 0, 0, 0, 1, 2, 0, 0, 1, 0));
    add("fr_hold_a3",  mi(1, 0, 1, 0, 0, 0, 0, 0, 0),         mo(0, 0, 0, 0, 0, 1, 3, 0, 0, 1, 0));
    add("fr_again",    mi(1, 0, 1, 0, 0, 0, 0, 0, 0),         mo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add("fr2_a0",      mi(1, 0, 0, 0, 0, 0, 0, 0, 0),         mo(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    add("fr2_a1",      mi(1, 0, 0, 0, 0, 0, 0, 0, 0),         mo(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0));
    // Reset at line 2 aborts the walk; init walk restarts from line 0 with no done pulse.
    add("rst_mid",     mi(0, 0, 0, 1, 'h3, 0, 0, 1, 'h4),     mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    add("re_a0",       mi(1, 0, 0, 0, 0, 0, 0, 0, 0),         mo(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    add("re_a1_lkp",   mi(1, 0, 0, 0, 0, 0, 0, 1, 'h5),       mo(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0));
    add("re_a2",       mi(1, 0, 0, 0, 0, 0, 0, 0, 0),         mo(0, 0, 0, 0, 0, 1, 2, 0, 0, 1, 0));
    add("re_a3",       mi(1, 0, 0, 0, 0, 0, 0, 0, 0),         mo(0, 0, 0, 0, 0, 1, 3, 0, 0, 1, 0));
    add("re_done",     mi(1, 0, 0, 0, 0, 0, 0, 0, 0),         mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    add("re_idle",     mi(1, 0, 0, 0, 0, 0, 0, 0, 0),         mo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    @(posedge clk); #1;
    foreach (tbl[k]) begin
      vec_t e;
      drive(tbl[k].i);
      exp_q.push_back(tbl[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      check(e.nm, 64'(act), 64'(e.o));
      @(posedge clk); #1;
    end

    stalled_walk();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
